// File: rtl/vrf_access_ctrl_pkg.sv
// Shared types and defaults for the vector register file access controller.
package vrf_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } sram_state_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Index width that stays legal when there is only one requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vrf_access_ctrl_if.sv
// Client-side handshake bundle: one write requester, NUM_RD read requesters.
interface vrf_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic [NUM_RD-1:0]            rd_valid;
    logic [NUM_RD-1:0]            rd_ready;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_rvalid;
    logic [DATA_WIDTH-1:0]        rd_rdata;
    logic                         busy;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata, busy
    );
endinterface

// File: rtl/vrf_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the winner when told the grant was taken.
module rr_arbiter
    import vrf_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0] ptr_q;

    // NOTE: every output gets a default before the search loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        // Scan from farthest to nearest so the requester closest to ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (update)
            ptr_q <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
    end

endmodule

// File: rtl/vrf_access_ctrl.sv
// Single-port register file SRAM controller: arbitrates one writer and NUM_RD
// readers, sequences bus direction and returns tagged read data.
module vrf_access_ctrl
    import vrf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD       = 2,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    vrf_access_ctrl_if.slave      bus,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);
    localparam int ID_W  = id_width(NUM_RD);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    sram_state_t           state_q, state_d;
    logic [CNT_W-1:0]      starve_q;
    logic [NUM_RD-1:0]     arb_gnt;
    logic [ID_W-1:0]       arb_idx;
    logic                  rd_pending, read_forced, wr_gnt, rd_gnt;
    logic [ADDR_WIDTH-1:0] rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ID_W-1:0]       id1_q, id2_q;
    logic                  ret_q;

    rr_arbiter #(.NUM_REQ(NUM_RD)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.rd_valid),
        .update    (rd_gnt),
        .grant     (arb_gnt),
        .grant_idx (arb_idx)
    );

    // Write wins unless readers have been starved; a write is never issued in the
    // cycle right after a read grant, so the macro gets a read or drain cycle first.
    always_comb begin
        rd_pending  = |bus.rd_valid;
        read_forced = rd_pending && (starve_q == CNT_W'(STARVE_LIMIT));
        wr_gnt      = !rst && bus.wr_valid && (state_q != RD) && !read_forced;
        rd_gnt      = !rst && rd_pending && !wr_gnt;
        rd_sel_addr = bus.rd_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign bus.wr_ready = wr_gnt;
    assign bus.rd_ready = rd_gnt ? arb_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst)
            starve_q <= '0;
        else if (rd_gnt || !rd_pending)
            starve_q <= '0;
        else if (wr_gnt)
            starve_q <= starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        if (wr_gnt)
            state_d = WR;
        else if (rd_gnt)
            state_d = RD;
        else if (state_q == RD)
            state_d = DRAIN;
    end

    always_comb begin
        sram_cs = 1'b0;
        sram_we = 1'b0;
        sram_oe = 1'b0;
        unique case (state_q)
            WR:        begin sram_cs = 1'b1; sram_we = 1'b1; end
            RD, DRAIN: begin sram_cs = 1'b1; sram_oe = 1'b1; end
            default:   ;
        endcase
    end

    // Address is held through DRAIN so the macro keeps presenting the last read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr <= '0;
            wr_data_q <= '0;
        end else if (wr_gnt) begin
            sram_addr <= bus.wr_addr;
            wr_data_q <= bus.wr_data;
        end else if (rd_gnt) begin
            sram_addr <= rd_sel_addr;
        end
    end

    assign sram_data = sram_we ? wr_data_q : 'z;

    // Requester id rides along two stages so it lines up with the captured bus data.
    always_ff @(posedge clk) begin
        if (rst) begin
            id1_q         <= '0;
            id2_q         <= '0;
            ret_q         <= 1'b0;
            bus.rd_rvalid <= '0;
            bus.rd_rdata  <= '0;
        end else begin
            if (rd_gnt)
                id1_q <= arb_idx;
            id2_q         <= id1_q;
            ret_q         <= (state_q == RD);
            bus.rd_rvalid <= ret_q ? (NUM_RD'(1) << id2_q) : '0;
            if (ret_q)
                bus.rd_rdata <= sram_data;
        end
    end

    assign bus.busy = (state_q == RD) || (state_q == DRAIN) || ret_q;

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Directed bench for vrf_access_ctrl with a behavioural macro and a read scoreboard.
module tb_vrf_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sram_cs, sram_we, sram_oe;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;

    always #5 clk = ~clk;

    vrf_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

    vrf_access_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_oe   (sram_oe),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    // Behavioural macro: synchronous write, registered read, drives only while oe.
    logic [DW-1:0] sram_mem [32];
    logic [DW-1:0] mac_dout;

    always @(posedge clk) begin
        if (sram_cs && sram_we)
            sram_mem[sram_addr] <= sram_data;
        if (sram_cs && sram_oe && !sram_we)
            mac_dout <= sram_mem[sram_addr];
    end

    assign sram_data = (sram_cs && sram_oe && !sram_we) ? mac_dout : 'z;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference contents as seen in issue order, plus the outstanding reads.
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            cyc;
    } sb_t;

    logic [DW-1:0] model_mem [32];
    sb_t           sb_q [$];
    sb_t           sb_e;
    int            mon_id;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (sram_we && sram_oe)
                check("we_oe_overlap", 32'(sram_we & sram_oe), 32'd0);
            if (bus.rd_rvalid != '0) begin
                if (sb_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(bus.rd_rvalid), 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_rvalid_id", 32'(bus.rd_rvalid), 32'(2'b01 << sb_e.id));
                    check("sb_rdata", bus.rd_rdata, sb_e.data);
                    check("sb_latency", 32'(cyc - sb_e.cyc), 32'd3);
                end
            end
            if (bus.wr_valid && bus.wr_ready)
                model_mem[bus.wr_addr] = bus.wr_data;
            if (bus.rd_ready != '0) begin
                mon_id = bus.rd_ready[1] ? 1 : 0;
                sb_q.push_back('{id: mon_id,
                                 data: model_mem[bus.rd_addr[mon_id*AW +: AW]],
                                 cyc: cyc});
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = '0;
        bus.rd_addr  = '0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 16 && sb_q.size() != 0; k++)
            next();
        next();
        mid();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [NR-1:0] gseq [8];

    initial begin
        for (int i = 0; i < 32; i++) begin
            sram_mem[i]  <= 32'hA500_0000 | 32'(i);
            model_mem[i]  = 32'hA500_0000 | 32'(i);
        end
        idle_inputs();
        rst = 1'b1;

        // Reset: requests present but nothing may be granted or driven.
        bus.wr_valid = 1'b1;
        bus.rd_valid = 2'b11;
        next(); next(); next();
        mid();
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("rst_rd_rvalid", 32'(bus.rd_rvalid), 32'd0);
        check("rst_rd_rdata", bus.rd_rdata, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sram_ctl", 32'({sram_cs, sram_we, sram_oe}), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        next();
        idle_inputs();
        rst = 1'b0;
        next();

        // Write then read of the same index.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd3;
        bus.wr_data  = 32'hDEADBEEF;
        mid();
        check("wtr_wr_ready", 32'(bus.wr_ready), 32'd1);
        next();
        idle_inputs();
        bus.rd_valid        = 2'b01;
        bus.rd_addr[0 +: AW] = 5'd3;
        mid();
        check("wtr_rd_ready", 32'(bus.rd_ready), 32'b01);
        next();
        bus.rd_valid = '0;
        mid();
        check("wtr_rd_cycle", 32'({sram_cs, sram_we, sram_oe, sram_addr}), 32'({3'b101, 5'd3}));
        check("wtr_busy", 32'(bus.busy), 32'd1);
        next(); next();
        mid();
        check("wtr_rvalid", 32'(bus.rd_rvalid), 32'b01);
        check("wtr_rdata", bus.rd_rdata, 32'hDEADBEEF);
        wait_drain();

        // Streaming reads from both requesters: pointer sits at 1 after the last grant.
        bus.rd_valid          = 2'b11;
        bus.rd_addr[0 +: AW]  = 5'd1;
        bus.rd_addr[AW +: AW] = 5'd2;
        for (int i = 0; i < 8; i++) begin
            gseq[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
            mid();
            check("stream_grant", 32'(bus.rd_ready), 32'(gseq[i]));
            if (i >= 3)
                check("stream_rvalid", 32'(bus.rd_rvalid), 32'(gseq[i-3]));
            next();
        end
        bus.rd_valid = '0;
        wait_drain();

        // Turnaround: write requested right after a read grant must wait one cycle.
        bus.rd_valid         = 2'b01;
        bus.rd_addr[0 +: AW] = 5'd5;
        mid();
        check("ta_rd_ready", 32'(bus.rd_ready), 32'b01);
        next();
        bus.rd_valid = '0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd9;
        bus.wr_data  = 32'h0000_1234;
        mid();
        check("ta_wr_stalled", 32'(bus.wr_ready), 32'd0);
        next();
        mid();
        check("ta_wr_granted", 32'(bus.wr_ready), 32'd1);
        next();
        idle_inputs();
        wait_drain();

        // All requesters active with an empty starvation count: write wins.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd12;
        bus.wr_data  = 32'hC0FF_EE00;
        bus.rd_valid = 2'b11;
        mid();
        check("sim_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("sim_rd_ready", 32'(bus.rd_ready), 32'd0);
        next();
        idle_inputs();
        next();

        // Starvation: four writes, then the pending read is forced through.
        bus.wr_valid          = 1'b1;
        bus.rd_valid          = 2'b10;
        bus.rd_addr[AW +: AW] = 5'd9;
        for (int i = 0; i < 4; i++) begin
            bus.wr_addr = 5'(10 + i);
            bus.wr_data = 32'h5000_0000 | 32'(i);
            mid();
            check("starve_wr_ready", 32'(bus.wr_ready), 32'd1);
            check("starve_rd_held", 32'(bus.rd_ready), 32'd0);
            next();
        end
        mid();
        check("starve_wr_blocked", 32'(bus.wr_ready), 32'd0);
        check("starve_rd_forced", 32'(bus.rd_ready), 32'b10);
        next();
        bus.rd_valid = '0;
        bus.wr_addr  = 5'd14;
        bus.wr_data  = 32'h5000_0004;
        mid();
        check("starve_ta", 32'(bus.wr_ready), 32'd0);
        next();
        mid();
        check("starve_resume", 32'(bus.wr_ready), 32'd1);
        next();
        idle_inputs();
        wait_drain();

        // Read-after-write ordering: the read issued right after the write sees it.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd6;
        bus.wr_data  = 32'h0000_0005;
        mid();
        check("raw_wr0", 32'(bus.wr_ready), 32'd1);
        next();
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'h0000_0009;
        mid();
        check("raw_wr1", 32'(bus.wr_ready), 32'd1);
        next();
        idle_inputs();
        bus.rd_valid         = 2'b01;
        bus.rd_addr[0 +: AW] = 5'd7;
        mid();
        check("raw_rd_ready", 32'(bus.rd_ready), 32'b01);
        next();
        bus.rd_valid = '0;
        next(); next();
        mid();
        check("raw_rvalid", 32'(bus.rd_rvalid), 32'b01);
        check("raw_rdata", bus.rd_rdata, 32'h0000_0009);
        wait_drain();

        // Reset during the RD cycle: the read is dropped and no write slips in.
        bus.rd_valid         = 2'b01;
        bus.rd_addr[0 +: AW] = 5'd3;
        mid();
        check("mrst_rd_ready", 32'(bus.rd_ready), 32'b01);
        next();
        bus.rd_valid = '0;
        rst          = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd4;
        bus.wr_data  = 32'h0000_0BAD;
        mid();
        check("mrst_in_rd", 32'(sram_oe), 32'd1);
        check("mrst_wr_gated", 32'(bus.wr_ready), 32'd0);
        next();
        rst = 1'b0;
        idle_inputs();
        mid();
        check("mrst_sram_ctl", 32'({sram_cs, sram_we, sram_oe}), 32'd0);
        check("mrst_sram_addr", 32'(sram_addr), 32'd0);
        check("mrst_rdata", bus.rd_rdata, 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("mrst_no_rvalid", 32'(bus.rd_rvalid), 32'd0);
            next();
            mid();
        end
        next();

        // The write presented during reset must not have reached the macro.
        bus.rd_valid          = 2'b10;
        bus.rd_addr[AW +: AW] = 5'd4;
        mid();
        check("post_rst_rd_ready", 32'(bus.rd_ready), 32'b10);
        next();
        bus.rd_valid = '0;
        next(); next();
        mid();
        check("post_rst_rdata", bus.rd_rdata, 32'hA500_0004);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
